// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch unit and the decode/control
// logic that sends redirects back to it.
//   DEF_ADDR_W    default PC/address width
//   INSTR_W       instruction word width
//   PC_STEP       byte increment between sequential fetches
//   fetch_state_t fetch FSM encoding (BOOT, RUN, HALT)
//   OP_*          opcodes of the instructions that can redirect fetch
package ifetch_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int INSTR_W    = 32;
  localparam int PC_STEP    = 4;

  typedef logic [1:0] fetch_state_t;
  localparam fetch_state_t BOOT = 2'd0;
  localparam fetch_state_t RUN  = 2'd1;
  localparam fetch_state_t HALT = 2'd2;

  localparam logic [5:0] OP_J   = 6'b000010;
  localparam logic [5:0] OP_JR  = 6'b001000;
  localparam logic [5:0] OP_BGT = 6'b000111;

endpackage

// File: rtl/ifetch_fifo.sv
// Small synchronous FIFO with flush. It serves both as the prefetch
// instruction buffer and as the in-order PC tag queue of the fetch unit.
// Ports:
//   clk, rst_n     clock, asynchronous active-low reset
//   flush          drop all entries (wins over push/pop)
//   push, wdata    write an entry; accepted when full only together with a pop
//   pop            remove the head (ignored when empty)
//   rdata          head entry
//   count          number of stored entries
//   full, empty    status flags
module ifetch_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 32,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rdata   = mem[rd_ptr];

  // Storage is reset so the head reads as zero straight out of reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (!do_push && do_pop) count <= count - CNT_W'(1);
    end
  end

  // The producer's credit scheme must never push into a full FIFO.
  always_ff @(posedge clk) begin
    if (rst_n && !flush) assert (!(push && full && !do_pop));
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues one-word reads to instruction
// memory, buffers returned words in a prefetch FIFO and hands them to decode
// with a valid/ready handshake. Redirects flush stale work and restart fetch.
// Optional build macro IFETCH_PERF_CNT_EN adds fetch_count/drop_count.
// Ports:
//   clk, rst_n                   clock, asynchronous active-low reset
//   imem_req, imem_addr          read request to instruction memory
//   imem_rvalid, imem_rdata      in-order read responses
//   instr_valid, instr, instr_pc head of the prefetch FIFO to decode
//   instr_ready                  decode consumes the head
//   redirect_valid, redirect_pc  restart fetch at a new PC
//   halt_req, halted             stop fetching / fully drained in HALT
//   fetch_count, drop_count      (optional) saturating event counters
//
// state | meaning
// BOOT  | single idle cycle after reset, no request
// RUN   | issuing sequential fetches while credit allows
// HALT  | no new requests; in-flight responses still drain
module instr_fetch_unit
  import ifetch_pkg::*;
#(
  parameter int                ADDR_W     = DEF_ADDR_W,
  parameter logic [ADDR_W-1:0] RESET_PC   = '0,
  parameter int                FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [ADDR_W-1:0]  instr_pc,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  input  logic               halt_req,
  output logic               halted
`ifdef IFETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_count,
  output logic [15:0]        drop_count
`endif
);

  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;
  localparam int DROP_W = 8;
  localparam logic [CNT_W:0] CREDIT_MAX = (CNT_W+1)'(FIFO_DEPTH);

  fetch_state_t              state;
  logic [ADDR_W-1:0]         fetch_pc;
  logic [DROP_W-1:0]         drop;
  logic [CNT_W-1:0]          tag_count;
  logic [CNT_W-1:0]          inst_count;
  logic [ADDR_W-1:0]         tag_pc;
  logic [INSTR_W+ADDR_W-1:0] inst_head;
  logic [CNT_W:0]            in_flight;
  logic                      issue;
  logic                      pop;
  logic                      resp_drop;
  logic                      resp_keep;
  logic                      tag_full, tag_empty, inst_full, inst_empty;
  logic [4:0]                unused_bits;

  assign unused_bits = {tag_full, tag_empty, inst_full, redirect_pc[1:0]};

  assign pop         = instr_valid && instr_ready;
  assign instr_valid = !inst_empty;
  assign {instr, instr_pc} = inst_head;

  // Outstanding requests are exactly the entries of the tag queue. A pop in
  // the same cycle frees a slot so the FIFO can stream one word per cycle.
  assign in_flight = {1'b0, tag_count} + {1'b0, inst_count} - {{CNT_W{1'b0}}, pop};
  assign issue     = (state == RUN) && !halt_req && !redirect_valid &&
                     (in_flight < CREDIT_MAX);

  // A response coinciding with a redirect belongs to work being flushed.
  assign resp_drop = imem_rvalid && (redirect_valid || (drop != '0));
  assign resp_keep = imem_rvalid && !redirect_valid && (drop == '0);

  assign imem_req  = issue;
  assign imem_addr = fetch_pc;
  assign halted    = (state == HALT) && (tag_count == '0) && (drop == '0);

  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(ADDR_W)) u_tag_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (issue),
    .wdata (fetch_pc),
    .pop   (resp_keep),
    .rdata (tag_pc),
    .count (tag_count),
    .full  (tag_full),
    .empty (tag_empty)
  );

  ifetch_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(INSTR_W + ADDR_W)) u_inst_q (
    .clk   (clk),
    .rst_n (rst_n),
    .flush (redirect_valid),
    .push  (resp_keep),
    .wdata ({imem_rdata, tag_pc}),
    .pop   (pop),
    .rdata (inst_head),
    .count (inst_count),
    .full  (inst_full),
    .empty (inst_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= BOOT;
    end else begin
      case (state)
        BOOT:    state <= RUN;
        RUN:     if (halt_req) state <= HALT;
        HALT:    if (!halt_req) state <= RUN;
        default: state <= BOOT;
      endcase
    end
  end

  // On a redirect every outstanding request becomes a response to discard;
  // one arriving in that same cycle is already discarded, hence the minus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_pc <= RESET_PC;
      drop     <= '0;
    end else if (redirect_valid) begin
      fetch_pc <= {redirect_pc[ADDR_W-1:2], 2'b00};
      drop     <= drop + DROP_W'(tag_count) - DROP_W'(imem_rvalid);
    end else begin
      if (issue)     fetch_pc <= fetch_pc + ADDR_W'(PC_STEP);
      if (resp_drop) drop     <= drop - DROP_W'(1);
    end
  end

`ifdef IFETCH_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fetch_count <= '0;
      drop_count  <= '0;
    end else begin
      if (pop && (fetch_count != '1))      fetch_count <= fetch_count + 32'(1);
      if (resp_drop && (drop_count != '1)) drop_count  <= drop_count + 16'(1);
    end
  end
`endif

endmodule
